// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions used by the ALU, its controllers and the arbiter.
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 3'b000;
  localparam alu_op_t ALU_SUB = 3'b001;
  localparam alu_op_t ALU_AND = 3'b010;
  localparam alu_op_t ALU_OR  = 3'b011;
  localparam alu_op_t ALU_XOR = 3'b100;
  localparam alu_op_t ALU_SLT = 3'b101;

  localparam int unsigned ALU_WIDTH = 32;

endpackage

// File: rtl/alu.sv
// 32-bit ALU: combinational result and zero flag; unknown opcodes give zero.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  alu_op_t              op,
  output logic [ALU_WIDTH-1:0] res,
  output logic                 zero
);

  // Operation select; SLT compares as signed two's complement.
  always_comb begin
    res = '0;
    case (op)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_SLT: res = {{(ALU_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: res = '0;
    endcase
    zero = (res == '0);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from rr_ptr with wrap-around and returns a
// one-hot grant, the winner index and the pointer to use after this grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [TAG_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [TAG_W-1:0]   grant_idx,
  output logic [TAG_W-1:0]   next_ptr
);

  localparam int unsigned N = NUM_REQ;

  logic found;

  // First valid requester at or after rr_ptr wins; inner loop keeps all indices constant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    next_ptr  = rr_ptr;
    found     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && (i == (32'(rr_ptr) + k) % N) && req_valid[i]) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = TAG_W'(i);
          next_ptr  = TAG_W'((i + 1) % N);
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin grant and a
// fixed two-stage pipeline (operand register, result register).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int TAG_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*WIDTH-1:0] req_imm,
  input  logic [NUM_REQ*3-1:0]     req_op,
  input  logic [NUM_REQ-1:0]       req_src,
  output logic                     rsp_valid,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [WIDTH-1:0]         rsp_res,
  output logic                     rsp_zero
);

  logic [TAG_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   grant_idx;
  logic [TAG_W-1:0]   next_ptr;

  logic [WIDTH-1:0]   win_a, win_b, win_imm;
  alu_op_t            win_op;
  logic               win_src;

  logic [WIDTH-1:0]   s1_a, s1_b, s1_imm;
  alu_op_t            s1_op;
  logic               s1_src;
  logic [TAG_W-1:0]   s1_tag;
  logic               s1_v;

  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_zero;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TAG_W  (TAG_W)
  ) u_rr (
    .req_valid(req_valid),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .grant_idx(grant_idx),
    .next_ptr (next_ptr)
  );

  // No grants are issued while reset is held.
  always_comb begin
    req_ready = rst ? '0 : grant;
  end

  // Select the winning requester's fields; grant is one-hot so at most one matches.
  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_imm = '0;
    win_op  = '0;
    win_src = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_a   = req_a[i*WIDTH +: WIDTH];
        win_b   = req_b[i*WIDTH +: WIDTH];
        win_imm = req_imm[i*WIDTH +: WIDTH];
        win_op  = req_op[i*3 +: 3];
        win_src = req_src[i];
      end
    end
  end

  // Round-robin pointer advances past the winner; holds when nobody is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= next_ptr;
    end
  end

  // Stage 1: capture the winner; data holds on idle cycles, only valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_imm <= '0;
      s1_op  <= '0;
      s1_src <= 1'b0;
      s1_tag <= '0;
      s1_v   <= 1'b0;
    end else begin
      s1_v <= |grant;
      if (|grant) begin
        s1_a   <= win_a;
        s1_b   <= win_b;
        s1_imm <= win_imm;
        s1_op  <= win_op;
        s1_src <= win_src;
        s1_tag <= grant_idx;
      end
    end
  end

  // ALUSrc mux in front of the ALU's second operand.
  always_comb begin
    alu_b = s1_src ? s1_imm : s1_b;
  end

  alu u_alu (
    .a   (s1_a),
    .b   (alu_b),
    .op  (s1_op),
    .res (alu_res),
    .zero(alu_zero)
  );

  // Stage 2: response registers hold their last value between valid pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_tag   <= '0;
      rsp_res   <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      rsp_valid <= s1_v;
      if (s1_v) begin
        rsp_tag  <= s1_tag;
        rsp_res  <= alu_res;
        rsp_zero <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (2-requester and 3-requester builds).
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst;

  logic [1:0]  v2;
  logic [1:0]  ready2;
  logic [63:0] a2, b2, imm2;
  logic [5:0]  op2;
  logic [1:0]  src2;
  logic        rv2;
  logic [0:0]  tag2;
  logic [31:0] res2;
  logic        z2;

  logic [2:0]  v3;
  logic [2:0]  ready3;
  logic [95:0] a3, b3, imm3;
  logic [8:0]  op3;
  logic [2:0]  src3;
  logic        rv3;
  logic [1:0]  tag3;
  logic [31:0] res3;
  logic        z3;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.NUM_REQ(2), .WIDTH(32)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(v2), .req_ready(ready2),
    .req_a(a2), .req_b(b2), .req_imm(imm2), .req_op(op2), .req_src(src2),
    .rsp_valid(rv2), .rsp_tag(tag2), .rsp_res(res2), .rsp_zero(z2)
  );

  alu_arbiter #(.NUM_REQ(3), .WIDTH(32)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(v3), .req_ready(ready3),
    .req_a(a3), .req_b(b3), .req_imm(imm3), .req_op(op3), .req_src(src3),
    .rsp_valid(rv3), .rsp_tag(tag3), .rsp_res(res3), .rsp_zero(z3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set2(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [2:0] op, input logic src);
    a2[i*32 +: 32]  = a;
    b2[i*32 +: 32]  = b;
    imm2[i*32 +: 32] = imm;
    op2[i*3 +: 3]   = op;
    src2[i]         = src;
  endtask

  task automatic set3(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [2:0] op, input logic src);
    a3[i*32 +: 32]  = a;
    b3[i*32 +: 32]  = b;
    imm3[i*32 +: 32] = imm;
    op3[i*3 +: 3]   = op;
    src3[i]         = src;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v2 = '0;
    v3 = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a2 = '0; b2 = '0; imm2 = '0; op2 = '0; src2 = '0;
    a3 = '0; b3 = '0; imm3 = '0; op3 = '0; src3 = '0;
    v2 = 2'b11;
    v3 = 3'b111;
    #3;
    checks++;
    if (ready2 !== 2'b00) begin errors++; $display("FAIL reset_ready2: got %b want 00", ready2); end
    checks++;
    if (ready3 !== 3'b000) begin errors++; $display("FAIL reset_ready3: got %b want 000", ready3); end
    v2 = '0;
    v3 = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rv2 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rv2); end
    checks++;
    if (tag2 !== 1'b0) begin errors++; $display("FAIL reset_rsp_tag: got %0d want 0", tag2); end
    checks++;
    if (res2 !== 32'd0) begin errors++; $display("FAIL reset_rsp_res: got %0h want 0", res2); end
    checks++;
    if (z2 !== 1'b0) begin errors++; $display("FAIL reset_rsp_zero: got %b want 0", z2); end
  endtask

  task automatic test_single();
    set2(0, 32'd5, 32'd3, 32'd0, ALU_ADD, 1'b0);
    v2 = 2'b01;
    #1;
    checks++;
    if (ready2 !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", ready2); end
    tick();
    v2 = '0;
    checks++;
    if (rv2 !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", rv2); end
    tick();
    checks++;
    if ({rv2, tag2, res2, z2} !== {1'b1, 1'b0, 32'd8, 1'b0})
      begin errors++; $display("FAIL single_rsp: got v=%b tag=%0d res=%0d z=%b want v=1 tag=0 res=8 z=0", rv2, tag2, res2, z2); end
    tick();
    checks++;
    if ({rv2, res2} !== {1'b0, 32'd8})
      begin errors++; $display("FAIL single_pulse_hold: got v=%b res=%0d want v=0 res=8", rv2, res2); end
  endtask

  task automatic test_imm_zero();
    set2(1, 32'd7, 32'd99, 32'd7, ALU_SUB, 1'b1);
    v2 = 2'b10;
    #1;
    checks++;
    if (ready2 !== 2'b10) begin errors++; $display("FAIL imm_ready: got %b want 10", ready2); end
    tick();
    v2 = '0;
    tick();
    checks++;
    if ({rv2, tag2, res2, z2} !== {1'b1, 1'b1, 32'd0, 1'b1})
      begin errors++; $display("FAIL imm_zero_rsp: got v=%b tag=%0d res=%0d z=%b want v=1 tag=1 res=0 z=1", rv2, tag2, res2, z2); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_ready [4];
    logic [31:0] exp_res [2];
    exp_ready[0] = 2'b01; exp_ready[1] = 2'b10; exp_ready[2] = 2'b01; exp_ready[3] = 2'b10;
    exp_res[0] = 32'h0000_0FF0;
    exp_res[1] = 32'd1;
    do_reset();
    set2(0, 32'h0000_0F00, 32'h0000_00F0, 32'd0, ALU_OR, 1'b0);
    set2(1, 32'hFFFF_FFFF, 32'd1, 32'd0, ALU_SLT, 1'b0);
    for (int c = 0; c < 6; c++) begin
      v2 = (c < 4) ? 2'b11 : 2'b00;
      #1;
      if (c < 4) begin
        checks++;
        if (ready2 !== exp_ready[c])
          begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", c, ready2, exp_ready[c]); end
      end
      if (c >= 2) begin
        checks++;
        if ({rv2, tag2, res2, z2} !== {1'b1, 1'((c - 2) % 2), exp_res[(c - 2) % 2], 1'b0})
          begin errors++; $display("FAIL rr_rsp[%0d]: got v=%b tag=%0d res=%0h z=%b want v=1 tag=%0d res=%0h z=0",
                                   c - 2, rv2, tag2, res2, z2, (c - 2) % 2, exp_res[(c - 2) % 2]); end
      end
      tick();
    end
    checks++;
    if (rv2 !== 1'b0) begin errors++; $display("FAIL rr_drain: got v=%b want 0", rv2); end
  endtask

  task automatic test_idle_gaps();
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      if (c == 1) set2(0, 32'h0000_FF00, 32'h0000_0FF0, 32'd0, ALU_XOR, 1'b0);
      if (c == 4) set2(0, 32'hFFFF_FFFF, 32'd1, 32'd0, ALU_ADD, 1'b0);
      v2 = (c == 1 || c == 4) ? 2'b01 : 2'b00;
      #1;
      checks++;
      if (rv2 !== ((c == 3 || c == 6) ? 1'b1 : 1'b0))
        begin errors++; $display("FAIL gap_valid[c%0d]: got %b want %b", c, rv2, (c == 3 || c == 6)); end
      if (c >= 3 && c <= 5) begin
        checks++;
        if ({res2, z2} !== {32'h0000_F0F0, 1'b0})
          begin errors++; $display("FAIL gap_res_hold[c%0d]: got res=%0h z=%b want res=f0f0 z=0", c, res2, z2); end
      end
      if (c == 6) begin
        checks++;
        if ({res2, z2} !== {32'd0, 1'b1})
          begin errors++; $display("FAIL gap_wrap_add: got res=%0h z=%b want res=0 z=1", res2, z2); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set2(0, 32'd40, 32'd2, 32'd0, ALU_ADD, 1'b0);
    v2 = 2'b01;
    tick();
    v2 = '0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rv2 !== 1'b0) begin errors++; $display("FAIL midflight_valid_rst: got %b want 0", rv2); end
    tick();
    checks++;
    if (rv2 !== 1'b0) begin errors++; $display("FAIL midflight_valid_hold: got %b want 0", rv2); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rv2 !== 1'b0) begin errors++; $display("FAIL midflight_valid_post: got %b want 0", rv2); end
    set2(0, 32'd2, 32'd2, 32'd0, ALU_ADD, 1'b0);
    set2(1, 32'd9, 32'd9, 32'd0, ALU_ADD, 1'b0);
    v2 = 2'b11;
    #1;
    checks++;
    if (ready2 !== 2'b01) begin errors++; $display("FAIL midflight_ptr0: got %b want 01", ready2); end
    tick();
    v2 = '0;
    checks++;
    if (rv2 !== 1'b0) begin errors++; $display("FAIL midflight_no_ghost: got %b want 0", rv2); end
    tick();
    checks++;
    if ({rv2, tag2, res2} !== {1'b1, 1'b0, 32'd4})
      begin errors++; $display("FAIL midflight_first_rsp: got v=%b tag=%0d res=%0d want v=1 tag=0 res=4", rv2, tag2, res2); end
  endtask

  task automatic test_wrap3();
    do_reset();
    set3(1, 32'd1, 32'd1, 32'd0, ALU_ADD, 1'b0);
    v3 = 3'b010;
    #1;
    checks++;
    if (ready3 !== 3'b010) begin errors++; $display("FAIL wrap_first: got %b want 010", ready3); end
    tick();
    set3(0, 32'd3, 32'd1, 32'd0, ALU_SUB, 1'b0);
    set3(2, 32'd6, 32'd100, 32'd1, ALU_OR, 1'b1);
    v3 = 3'b101;
    #1;
    checks++;
    if (ready3 !== 3'b100) begin errors++; $display("FAIL wrap_grant2: got %b want 100", ready3); end
    tick();
    #1;
    checks++;
    if (ready3 !== 3'b001) begin errors++; $display("FAIL wrap_grant0: got %b want 001", ready3); end
    checks++;
    if ({rv3, tag3, res3} !== {1'b1, 2'd1, 32'd2})
      begin errors++; $display("FAIL wrap_rsp1: got v=%b tag=%0d res=%0d want v=1 tag=1 res=2", rv3, tag3, res3); end
    tick();
    v3 = 3'b111;
    #1;
    checks++;
    if (ready3 !== 3'b010) begin errors++; $display("FAIL wrap_ptr_end: got %b want 010", ready3); end
    checks++;
    if ({rv3, tag3, res3} !== {1'b1, 2'd2, 32'd7})
      begin errors++; $display("FAIL wrap_rsp2: got v=%b tag=%0d res=%0d want v=1 tag=2 res=7", rv3, tag3, res3); end
    tick();
    v3 = '0;
    #1;
    checks++;
    if ({rv3, tag3, res3} !== {1'b1, 2'd0, 32'd2})
      begin errors++; $display("FAIL wrap_rsp0: got v=%b tag=%0d res=%0d want v=1 tag=0 res=2", rv3, tag3, res3); end
    tick();
    checks++;
    if ({rv3, tag3, res3} !== {1'b1, 2'd1, 32'd2})
      begin errors++; $display("FAIL wrap_rsp1b: got v=%b tag=%0d res=%0d want v=1 tag=1 res=2", rv3, tag3, res3); end
    tick();
    checks++;
    if (rv3 !== 1'b0) begin errors++; $display("FAIL wrap_drain: got %b want 0", rv3); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_imm_zero();
    test_contention();
    test_idle_gaps();
    test_reset_midflight();
    test_wrap3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU instance between NUM_REQ requesters, for example the main execute path and a branch/address-compute path.
- Round-robin grant each cycle; the winner's operands and controls are registered into the ALU input stage, and the ALU result and zero flag are registered into a tagged response.
- Fixed 2-cycle request-to-response latency, fully pipelined: one accepted request per cycle.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- WIDTH, 32, operand/result width; the ALU instance is fixed at 32.
- TAG_W, $clog2(NUM_REQ) (min 1), width of the grant tag.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request.
- req_ready  output  NUM_REQ  one-hot grant; combinational from req_valid and rr_ptr.
- req_a  input  NUM_REQ*WIDTH  operand A; slice i belongs to requester i.
- req_b  input  NUM_REQ*WIDTH  register operand B.
- req_imm  input  NUM_REQ*WIDTH  extended immediate.
- req_op  input  NUM_REQ*3  ALUOp.
- req_src  input  NUM_REQ  ALUSrc: 1 selects imm, 0 selects B.
- rsp_valid  output  1  response valid, one-cycle pulse per accepted request.
- rsp_tag  output  TAG_W  index of the requester the response belongs to.
- rsp_res  output  WIDTH  ALU Res.
- rsp_zero  output  1  ALU Zero.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - rsp_valid=0, rsp_tag=0, rsp_res=0, rsp_zero=0.
  - Stage-1 registers cleared, stage-1 valid s1_v=0.
  - rr_ptr=0.
  - req_ready is all-zero while rst is high.
- Arbitration (cycle N):
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; the vector is one-hot or all-zero.
  - A handshake occurs when valid and ready are both high in the same cycle.
  - Grant depends only on current req_valid and rr_ptr; there is no backpressure and no hold.
- rr_ptr update: on a grant to requester i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Stage 1 (edge ending cycle N):
  - s1_a, s1_b, s1_imm, s1_op, s1_src, s1_tag <= the winner's fields.
  - s1_v <= |req_ready.
  - With no grant, s1_v <= 0 and the data registers hold their value (not cleared).
- ALU: combinational from the stage-1 registers during cycle N+1.
- Stage 2 (edge ending cycle N+1):
  - rsp_res, rsp_zero, rsp_tag <= ALU outputs and s1_tag.
  - rsp_valid <= s1_v.
  - Outputs are visible during cycle N+2. Latency is exactly 2 edges from the handshake.
- rsp_valid is high for exactly one cycle per accepted request.
- rsp_res, rsp_zero and rsp_tag hold their last value when rsp_valid=0.
- Back-to-back: requests accepted on consecutive cycles produce responses on consecutive cycles, in acceptance order.
- A requester that keeps req_valid high may be granted again only after the other active requesters have each been served once (no starvation; worst-case wait NUM_REQ-1 cycles).
- Reset mid-flight: in-flight stage-1/stage-2 contents are discarded and no response is produced for them.
- Unsupported req_op encodings pass through to the ALU unchanged. The arbiter never alters op, src or operands.

Decomposition:
- Shared package alu_pkg holds the ALUOp localparams ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_XOR=3'b100, ALU_SLT=3'b101. The ALU and its controllers also use these.
- One natural sub-module, rr_arbiter (NUM_REQ): takes req_valid and rr_ptr, produces the one-hot grant and the next pointer.
- The ALU is instantiated directly in alu_arbiter.

Test Plan:
- Reset then single request: req0 only, a=5, b=3, op=ADD, src=0 at cycle 1 -> req_ready=2'b01 in cycle 1; rsp_valid=1, tag=0, res=8, zero=0 in cycle 3.
- Immediate select and zero flag: req1 only, a=7, b=99, imm=7, op=SUB, src=1 -> tag=1, res=0, zero=1 two cycles later.
- Contention and round-robin: both requesters valid for 4 cycles from reset -> grants 0,1,0,1; four consecutive rsp_valid pulses with tags 0,1,0,1 and correct results.
- Idle gaps: requests at cycles 1 and 4 only -> rsp_valid high at cycles 3 and 6 only; rsp_res holds its value in between.
- Reset mid-flight: grant at cycle 1, rst asserted during cycle 2 -> rsp_valid stays 0 through reset; the first post-reset request is served from rr_ptr=0.
- Wrap-around with NUM_REQ=3: requests from 2 and 0 with rr_ptr=2 -> grant 2 first, then 0; rr_ptr ends at 1.
